// File: rtl/exponent_bias_adder_pkg.sv
// Shared FP exponent constants and types for the bit-serial bias adder.
// Also home of the state encoding used by the FSM.
package exponent_bias_adder_pkg;

  localparam int FP_EXP_BIAS       = 127;
  localparam int FP_EXP_MAX_BIASED = 254;
  localparam int FP_EXP_WIDTH      = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] biased;
    logic       overflow;
    logic       underflow;
  } result_t;

endpackage

// File: rtl/exponent_bias_adder_if.sv
// Valid/ready handshake bundle for the exponent re-biasing unit.
// The slave modport is the adder; the master modport is the producer/consumer side.
interface exponent_bias_adder_if #(
  parameter int WIDTH = 9
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] exp_in;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       biased_out;
  logic             overflow;
  logic             underflow;

  modport slave (
    input  in_valid, exp_in, out_ready,
    output in_ready, out_valid, biased_out, overflow, underflow
  );

  modport master (
    output in_valid, exp_in, out_ready,
    input  in_ready, out_valid, biased_out, overflow, underflow
  );
endinterface

// File: rtl/exponent_bias_adder_full_adder_bit.sv
// Single-bit full adder: the only arithmetic cell in the serial loop.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/exponent_bias_adder.sv
// Bit-serial exponent re-biasing: adds BIAS to a signed WIDTH-bit exponent LSB first
// and saturates the result into an 8-bit biased exponent field with over/underflow flags.
module exponent_bias_adder
  import exponent_bias_adder_pkg::*;
#(
  parameter int WIDTH = FP_EXP_WIDTH,
  parameter int BIAS  = FP_EXP_BIAS
) (
  input  logic                 clk,
  input  logic                 rst,
  exponent_bias_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH:0]   r_a;
  logic [WIDTH:0]   r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  result_t          r_out;

  logic             w_sum;
  logic             w_cout;
  logic             w_last;
  logic [WIDTH:0]   w_s;
  result_t          w_res;

  full_adder_bit u_fa (
    .a   (r_a[0]),
    .b   (r_b[0]),
    .cin (r_carry),
    .s   (w_sum),
    .cout(w_cout)
  );

  assign w_last = (r_cnt == CW'(WIDTH));
  // On the final SHIFT cycle the top sum bit is still combinational, so the
  // complete sum is the live adder output on top of the stored lower bits.
  assign w_s    = {w_sum, r_res};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.in_valid) w_next = ST_SHIFT;
      ST_SHIFT: if (w_last)       w_next = ST_DONE;
      ST_DONE:  if (bus.out_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_res = '0;
    if (w_s[WIDTH] || (w_s == '0)) begin
      w_res.underflow = 1'b1;
    end else if (w_s[WIDTH-1:0] > WIDTH'(FP_EXP_MAX_BIASED)) begin
      w_res.overflow = 1'b1;
      w_res.biased   = 8'hFF;
    end else begin
      w_res.biased   = w_s[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_out   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_a     <= {bus.exp_in[WIDTH-1], bus.exp_in};
            r_b     <= (WIDTH + 1)'(BIAS);
            r_carry <= 1'b0;
            r_cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          r_res   <= {w_sum, r_res[WIDTH-1:1]};
          r_carry <= w_cout;
          r_a     <= {1'b0, r_a[WIDTH:1]};
          r_b     <= {1'b0, r_b[WIDTH:1]};
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) r_out <= w_res;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = (r_state == ST_IDLE);
  assign bus.out_valid  = (r_state == ST_DONE);
  assign bus.biased_out = r_out.biased;
  assign bus.overflow   = r_out.overflow;
  assign bus.underflow  = r_out.underflow;

endmodule

// File: tb/tb_exponent_bias_adder.sv
// Directed, table-driven bench for exponent_bias_adder plus backpressure,
// mid-operation reset and back-to-back sequences.
module tb_exponent_bias_adder;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  exponent_bias_adder_if #(.WIDTH(9)) bus ();

  exponent_bias_adder dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] e;
    logic [7:0] b;
    logic       ov;
    logic       un;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Offer one exponent with out_ready high, check latency, result and release.
  task automatic do_xfer(input logic [8:0] e, input logic [7:0] b, input logic ov,
                         input logic un, input string tag);
    int n;
    @(negedge clk);
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.exp_in    = e;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk({tag, " latency"}, 32'(n), 32'd10);
    chk({tag, " result"}, {22'd0, bus.biased_out, ov ? 1'b1 : 1'b0, bus.overflow},
        {22'd0, b, ov, ov});
    chk({tag, " underflow"}, 32'(bus.underflow), 32'(un));
    @(posedge clk);
    #1;
    chk({tag, " release"}, {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
  endtask

  initial begin
    int n;
    vecs[0] = '{9'd0,   8'd127, 1'b0, 1'b0};
    vecs[1] = '{9'd127, 8'd254, 1'b0, 1'b0};
    vecs[2] = '{9'h182, 8'd1,   1'b0, 1'b0};
    vecs[3] = '{9'd128, 8'hFF,  1'b1, 1'b0};
    vecs[4] = '{9'h181, 8'h00,  1'b0, 1'b1};
    vecs[5] = '{9'h100, 8'h00,  1'b0, 1'b1};
    vecs[6] = '{9'd255, 8'hFF,  1'b1, 1'b0};
    vecs[7] = '{9'h1FF, 8'd126, 1'b0, 1'b0};
    vecs[8] = '{9'h180, 8'h00,  1'b0, 1'b1};
    vecs[9] = '{9'd100, 8'd227, 1'b0, 1'b0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.exp_in    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", {27'd0, bus.in_ready, bus.out_valid, bus.overflow, bus.underflow,
        |bus.biased_out}, 32'b10000);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      do_xfer(vecs[i].e, vecs[i].b, vecs[i].ov, vecs[i].un, $sformatf("vec%0d", i));

    // Backpressure with an ignored in_valid pulse while DONE is held.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.exp_in    = 9'd5;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("bp latency", 32'(n), 32'd10);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 2) begin
        bus.in_valid = 1'b1;
        bus.exp_in   = 9'd50;
      end
      if (i == 4) bus.in_valid = 1'b0;
      chk($sformatf("bp hold%0d", i), {22'd0, bus.out_valid, bus.in_ready, bus.biased_out},
          {22'd0, 1'b1, 1'b0, 8'd132});
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release", {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) n++;
    end
    chk("bp no ghost result", 32'(n), 32'd0);

    // Reset in the middle of the serial add.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.exp_in   = 9'd10;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid reset", {27'd0, bus.in_ready, bus.out_valid, bus.overflow, bus.underflow,
        |bus.biased_out}, 32'b10000);
    @(negedge clk);
    rst = 1'b0;
    do_xfer(9'h1FF, 8'd126, 1'b0, 1'b0, "after_reset");

    // Back-to-back with out_ready high.
    for (int i = 1; i <= 3; i++)
      do_xfer(9'(i), 8'(127 + i), 1'b0, 1'b0, $sformatf("b2b%0d", i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
